midi_msg_parser: RTL and testbench
==================================

// Module: midi_msg_parser
// PURPOSE
//  Consumes the received byte stream from the MIDI UART receiver and assembles complete MIDI messages.
//  Resolves running status, data-byte counts, SysEx streaming and interleaved real-time bytes.
//  Buffers assembled messages in a small FIFO and presents them on a valid/ready port to the voice/controller logic.
//  All logic runs on CLOCK_25. The byte strobe arrives from the midi_clk domain and is synchronised here.
// PARAMETERS
//  FIFO_DEPTH   4   messages buffered; power of two, at least 2
//  SYNC_STAGES  2   flops on the byte_ready synchroniser; at least 2
// PORTS
//  CLOCK_25     in   1  system clock
//  iRST         in   1  reset, asynchronous, active-high
//  byte_ready   in   1  UART byte strobe (midi_clk domain, level lasting >=1 midi_clk period)
//  midi_byte    in   8  received byte; stable while byte_ready is high
//  msg_valid    out  1  FIFO head holds a message
//  msg_ready    in   1  consumer accepts the head when msg_valid && msg_ready
//  msg_status   out  8  status byte (F0 for SysEx payload, F7 for SysEx end)
//  msg_data1    out  8  first data byte, 0 if unused
//  msg_data2    out  8  second data byte, 0 if unused
//  msg_len      out  2  number of valid data bytes (0..2)
//  overflow     out  1  sticky; set when a message is dropped on a full FIFO
//  ovf_clr      in   1  clears overflow; set wins if set and clear occur in the same cycle
//  chan_sel     in   4  channel to accept (used only with MIDI_CHAN_FILTER_EN)
// BEHAVIOUR
//  Reset (async, any time, including mid-message): FSM=NOSTAT, running status=0, FIFO empty.
//   Outputs: msg_valid=0, msg_*=0, msg_len=0, overflow=0.
//  Ingress: byte_ready passes through SYNC_STAGES flops, then a rising-edge detect forms a 1-cycle strobe.
//   midi_byte is sampled on that strobe. Exactly one byte is taken per byte_ready rising edge.
//  Latency: message completes on strobe cycle S; FIFO is written at S+1; msg_valid rises at S+2 when the FIFO was empty.
//  FSM states: NOSTAT, WAIT_D1, WAIT_D2, SYSEX.
//   Real-time bytes F8..FF: F8,FA,FB,FC,FE,FF push {byte,0,0,len0} immediately; F9,FD are ignored.
//    Real-time bytes never change the state, running status or partial data.
//   Channel status 8n,9n,An,Bn,En: running status=byte, data count=2, go to WAIT_D1.
//   Channel status Cn,Dn: running status=byte, data count=1, go to WAIT_D1.
//   F1, F3: data count 1. F2: data count 2. Running status is cleared; go to WAIT_D1.
//   F6: push {F6,len0}, clear running status, go to NOSTAT.
//   F4, F5: clear running status, go to NOSTAT, push nothing.
//   F0: clear running status, go to SYSEX.
//   F7: in SYSEX, push {F7,len0} and go to NOSTAT; otherwise ignored.
//   Any new status byte discards an incomplete message without pushing it.
//   Data byte (bit7=0):
//    NOSTAT: discarded.
//    WAIT_D1: latch d1; if data count=1, push with len1, else go to WAIT_D2.
//    WAIT_D2: push with len2. Return to WAIT_D1 when running status!=0 (running status), else NOSTAT.
//    SYSEX: push {F0,byte,0,len1}; stay in SYSEX.
//  FIFO: first-word-fall-through.
//   Push when full: message dropped, overflow set.
//   Simultaneous push and pop when full: both succeed, no overflow.
//   Pop when empty: no effect. Pointers wrap modulo FIFO_DEPTH.
//   msg_* hold the head value and are 0 while empty.
// CONFIGURATION
//  MIDI_CHAN_FILTER_EN defined: completed channel messages (80..EF) whose low nibble != chan_sel are not pushed.
//   Running status is still tracked for them. System and real-time messages always pass.
//  Not defined: chan_sel is ignored and all messages pass.
// STRUCTURE
//  midi_pkg holds:
//   Status range constants (NOTE_OFF..PITCH_BEND, SYSEX_START/END, RT_*).
//   A data_count(status) function.
//   FSM state encodings.
//   MSG_W=26 message word layout {status,d1,d2,len}.
//  Sub-module midi_msg_fifo (MSG_W x FIFO_DEPTH, FWFT, full/empty) is instantiated once.
// TESTING
//  Bytes 90 3C 64 -> one msg {90,3C,64,2}; msg_valid at S+2 of the last byte.
//  Bytes 90 3C 64 40 00 -> two msgs {90,3C,64,2} and {90,40,00,2} (running status).
//  Bytes 90 3C F8 64 -> {F8,0,0,0} then {90,3C,64,2}; the real-time byte does not break the note message.
//  Bytes F0 7E 01 F7 -> {F0,7E,0,1}, {F0,01,0,1}, {F7,0,0,0}; then 3C alone is discarded.
//  msg_ready=0, six C0 xx messages with FIFO_DEPTH=4 -> 4 queued, overflow=1; ovf_clr pulse -> 0.
//  MIDI_CHAN_FILTER_EN, chan_sel=2 -> 92 3C 64 passes, 93 3C 64 is dropped; iRST during 90 3C -> 64 is discarded.

Source files
------------

// File: rtl/midi_pkg.sv
// MIDI message parser shared definitions: status byte constants, FSM states and the message word layout.
package midi_pkg;

    localparam logic [7:0] NOTE_OFF    = 8'h80;
    localparam logic [7:0] NOTE_ON     = 8'h90;
    localparam logic [7:0] POLY_AT     = 8'hA0;
    localparam logic [7:0] CTRL_CHG    = 8'hB0;
    localparam logic [7:0] PROG_CHG    = 8'hC0;
    localparam logic [7:0] CHAN_AT     = 8'hD0;
    localparam logic [7:0] PITCH_BEND  = 8'hE0;
    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] MTC_QF      = 8'hF1;
    localparam logic [7:0] SONG_POS    = 8'hF2;
    localparam logic [7:0] SONG_SEL    = 8'hF3;
    localparam logic [7:0] TUNE_REQ    = 8'hF6;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_CLOCK    = 8'hF8;
    localparam logic [7:0] RT_TICK     = 8'hF9;
    localparam logic [7:0] RT_UNDEF    = 8'hFD;

    localparam int MSG_W = 26;

    typedef enum logic [1:0] {NOSTAT, WAIT_D1, WAIT_D2, SYSEX} state_t;

    typedef struct packed {
        logic [7:0] status;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [1:0] len;
    } msg_t;

    function automatic logic [1:0] data_count(input logic [7:0] s);
        logic [1:0] n;
        n = 2'd0;
        if (s[7:4] == NOTE_OFF[7:4] || s[7:4] == NOTE_ON[7:4] || s[7:4] == POLY_AT[7:4] ||
            s[7:4] == CTRL_CHG[7:4] || s[7:4] == PITCH_BEND[7:4] || s == SONG_POS)
            n = 2'd2;
        else if (s[7:4] == PROG_CHG[7:4] || s[7:4] == CHAN_AT[7:4] || s == MTC_QF || s == SONG_SEL)
            n = 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/midi_msg_parser_if.sv
// Message output port of the MIDI parser: FWFT head of the message queue with valid/ready.
interface midi_msg_parser_if;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] msg_status;
    logic [7:0] msg_data1;
    logic [7:0] msg_data2;
    logic [1:0] msg_len;

    modport master (output msg_valid, msg_status, msg_data1, msg_data2, msg_len, input msg_ready);
    modport slave  (input msg_valid, msg_status, msg_data1, msg_data2, msg_len, output msg_ready);
endinterface

// File: rtl/midi_msg_fifo.sv
// First-word-fall-through message queue; a push on a full queue is accepted only alongside a pop.
module midi_msg_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end
endmodule

// File: rtl/midi_msg_parser.sv
// Assembles MIDI messages from the synchronised UART byte strobe and queues them for the consumer.
// MIDI_CHAN_FILTER_EN: when defined, completed channel messages not on chan_sel are not queued.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLOCK_25,
    input  logic                iRST,
    input  logic                byte_ready,
    input  logic [7:0]          midi_byte,
    midi_msg_parser_if.master   msg,
    output logic                overflow,
    input  logic                ovf_clr,
    input  logic [3:0]          chan_sel
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   strobe;
    state_t                 state_q, state_d;
    logic [7:0]             run_q, run_d, cur_q, cur_d, d1_q, d1_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   push_q, push_d;
    msg_t                   push_msg_q, push_msg_d;
    logic                   overflow_q, overflow_d;
    logic                   chan_pass, fifo_full, fifo_empty, pop;
    logic [MSG_W-1:0]       head_w;
    msg_t                   head;

    assign strobe = sync_q[SYNC_STAGES-1] && !prev_q;

`ifdef MIDI_CHAN_FILTER_EN
    assign chan_pass = !(cur_q >= NOTE_OFF && cur_q < SYSEX_START) || (cur_q[3:0] == chan_sel);
`else
    logic chan_sel_unused;
    assign chan_sel_unused = ^chan_sel;
    assign chan_pass       = 1'b1;
`endif

    always_ff @(posedge CLOCK_25 or posedge iRST) begin
        if (iRST) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            state_q    <= NOSTAT;
            run_q      <= '0;
            cur_q      <= '0;
            d1_q       <= '0;
            cnt_q      <= '0;
            push_q     <= 1'b0;
            push_msg_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], byte_ready};
            prev_q     <= sync_q[SYNC_STAGES-1];
            state_q    <= state_d;
            run_q      <= run_d;
            cur_q      <= cur_d;
            d1_q       <= d1_d;
            cnt_q      <= cnt_d;
            push_q     <= push_d;
            push_msg_q <= push_msg_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        cur_d      = cur_q;
        d1_d       = d1_q;
        cnt_d      = cnt_q;
        push_d     = 1'b0;
        push_msg_d = '0;
        if (strobe) begin
            // Real-time bytes leave every piece of assembly state untouched.
            if (midi_byte >= RT_CLOCK) begin
                if (midi_byte != RT_TICK && midi_byte != RT_UNDEF) begin
                    push_d            = 1'b1;
                    push_msg_d.status = midi_byte;
                end
            end else if (midi_byte[7] && midi_byte < SYSEX_START) begin
                run_d   = midi_byte;
                cur_d   = midi_byte;
                cnt_d   = data_count(midi_byte);
                state_d = WAIT_D1;
            end else if (midi_byte[7]) begin
                case (midi_byte)
                    SYSEX_START: begin
                        run_d   = '0;
                        state_d = SYSEX;
                    end
                    MTC_QF, SONG_POS, SONG_SEL: begin
                        run_d   = '0;
                        cur_d   = midi_byte;
                        cnt_d   = data_count(midi_byte);
                        state_d = WAIT_D1;
                    end
                    TUNE_REQ: begin
                        run_d             = '0;
                        state_d           = NOSTAT;
                        push_d            = 1'b1;
                        push_msg_d.status = TUNE_REQ;
                    end
                    SYSEX_END: begin
                        if (state_q == SYSEX) begin
                            state_d           = NOSTAT;
                            push_d            = 1'b1;
                            push_msg_d.status = SYSEX_END;
                        end
                    end
                    default: begin
                        run_d   = '0;
                        state_d = NOSTAT;
                    end
                endcase
            end else begin
                case (state_q)
                    NOSTAT: ;
                    WAIT_D1: begin
                        d1_d = midi_byte;
                        if (cnt_q == 2'd1) begin
                            push_d     = chan_pass;
                            push_msg_d = '{status: cur_q, d1: midi_byte, d2: 8'h00, len: 2'd1};
                            state_d    = (run_q != '0) ? WAIT_D1 : NOSTAT;
                        end else begin
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        push_d     = chan_pass;
                        push_msg_d = '{status: cur_q, d1: d1_q, d2: midi_byte, len: 2'd2};
                        state_d    = (run_q != '0) ? WAIT_D1 : NOSTAT;
                    end
                    SYSEX: begin
                        push_d     = 1'b1;
                        push_msg_d = '{status: SYSEX_START, d1: midi_byte, d2: 8'h00, len: 2'd1};
                    end
                endcase
            end
        end
    end

    assign pop = msg.msg_valid && msg.msg_ready;

    // Set wins over clear; a push that coincides with a pop on a full queue is not a drop.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) overflow_d = 1'b0;
        if (push_q && fifo_full && !pop) overflow_d = 1'b1;
    end

    midi_msg_fifo #(.W(MSG_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (CLOCK_25),
        .rst        (iRST),
        .push_i     (push_q),
        .push_dat_i (push_msg_q),
        .pop_i      (pop),
        .head_o     (head_w),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign head           = head_w;
    assign overflow       = overflow_q;
    assign msg.msg_valid  = !fifo_empty;
    assign msg.msg_status = fifo_empty ? 8'h00 : head.status;
    assign msg.msg_data1  = fifo_empty ? 8'h00 : head.d1;
    assign msg.msg_data2  = fifo_empty ? 8'h00 : head.d2;
    assign msg.msg_len    = fifo_empty ? 2'd0  : head.len;
endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed-vector bench for midi_msg_parser: byte sequences in, queued messages checked against hand values.
module tb_midi_msg_parser;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       byte_ready = 1'b0;
    logic [7:0] midi_byte = 8'h00;
    logic       overflow;
    logic       ovf_clr = 1'b0;
    logic [3:0] chan_sel = 4'd2;
    int         n_vec = 0;
    int         n_err = 0;

    midi_msg_parser_if mif ();

    midi_msg_parser #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .CLOCK_25   (clk),
        .iRST       (rst),
        .byte_ready (byte_ready),
        .midi_byte  (midi_byte),
        .msg        (mif),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .chan_sel   (chan_sel)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        midi_byte  = b;
        byte_ready = 1'b1;
        repeat (6) @(negedge clk);
        byte_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Exact-timing byte: optionally checks msg_valid at S+1/S+2 and pops on the write cycle.
    task automatic send_timed(input logic [7:0] b, input bit chk_lat, input bit pop_at_wr);
        @(negedge clk);
        midi_byte  = b;
        byte_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (chk_lat) chk("lat_s1_vld", {31'd0, mif.msg_valid}, 32'd0);
        if (pop_at_wr) begin
            @(negedge clk);
            mif.msg_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        if (chk_lat) chk("lat_s2_vld", {31'd0, mif.msg_valid}, 32'd1);
        @(negedge clk);
        mif.msg_ready = 1'b0;
        repeat (3) @(negedge clk);
        byte_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] st, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [1:0] len);
        int t;
        t = 0;
        while (!mif.msg_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_vld"}, {31'd0, mif.msg_valid}, 32'd1);
        chk(tag, {6'd0, mif.msg_status, mif.msg_data1, mif.msg_data2, mif.msg_len},
            {6'd0, st, d1, d2, len});
        mif.msg_ready = 1'b1;
        @(negedge clk);
        mif.msg_ready = 1'b0;
    endtask

    task automatic expect_empty(input string tag);
        repeat (4) @(negedge clk);
        chk(tag, {31'd0, mif.msg_valid}, 32'd0);
    endtask

    initial begin
        mif.msg_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vld", {31'd0, mif.msg_valid}, 32'd0);
        chk("rst_word", {6'd0, mif.msg_status, mif.msg_data1, mif.msg_data2, mif.msg_len}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Note on with exact latency, then running status
        send_byte(8'h90);
        send_byte(8'h3C);
        send_timed(8'h64, 1'b1, 1'b0);
        pop_expect("note_on", 8'h90, 8'h3C, 8'h64, 2'd2);
        expect_empty("note_on_drained");
        send_byte(8'h40);
        send_byte(8'h00);
        pop_expect("run_stat", 8'h90, 8'h40, 8'h00, 2'd2);

        // Real-time byte interleaved mid-message
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'hF8);
        send_byte(8'h64);
        pop_expect("rt_f8", 8'hF8, 8'h00, 8'h00, 2'd0);
        pop_expect("rt_note", 8'h90, 8'h3C, 8'h64, 2'd2);

        // SysEx stream, then a stray data byte
        send_byte(8'hF0);
        send_byte(8'h7E);
        send_byte(8'h01);
        send_byte(8'hF7);
        pop_expect("sx_d0", 8'hF0, 8'h7E, 8'h00, 2'd1);
        pop_expect("sx_d1", 8'hF0, 8'h01, 8'h00, 2'd1);
        pop_expect("sx_end", 8'hF7, 8'h00, 8'h00, 2'd0);
        send_byte(8'h3C);
        expect_empty("stray_data");

        // System common, ignored real-time, one-byte channel messages, status interrupt
        send_byte(8'hF9);
        send_byte(8'hF6);
        pop_expect("tune_req", 8'hF6, 8'h00, 8'h00, 2'd0);
        send_byte(8'hF1);
        send_byte(8'h12);
        pop_expect("mtc_qf", 8'hF1, 8'h12, 8'h00, 2'd1);
        send_byte(8'h34);
        expect_empty("f1_no_run");
        send_byte(8'hC5);
        send_byte(8'h10);
        send_byte(8'h11);
        pop_expect("prog_a", 8'hC5, 8'h10, 8'h00, 2'd1);
        pop_expect("prog_b", 8'hC5, 8'h11, 8'h00, 2'd1);
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'h82);
        send_byte(8'h3D);
        send_byte(8'h00);
        pop_expect("interrupt", 8'h82, 8'h3D, 8'h00, 2'd2);
        expect_empty("interrupt_only");

        // Full queue: push coinciding with pop is kept, no overflow
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'hC0);
            send_byte(8'(i));
        end
        send_byte(8'hC0);
        send_timed(8'h05, 1'b0, 1'b1);
        chk("pushpop_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 2; i <= 5; i++) pop_expect("pushpop_q", 8'hC0, 8'(i), 8'h00, 2'd1);
        expect_empty("pushpop_drained");

        // Overflow: six messages into a four-deep queue
        for (int i = 0; i < 6; i++) begin
            send_byte(8'hC0);
            send_byte(8'(8'h10 + i));
        end
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) pop_expect("ovf_q", 8'hC0, 8'(8'h10 + i), 8'h00, 2'd1);
        expect_empty("ovf_dropped");

`ifdef MIDI_CHAN_FILTER_EN
        send_byte(8'h92);
        send_byte(8'h3C);
        send_byte(8'h64);
        pop_expect("filt_pass", 8'h92, 8'h3C, 8'h64, 2'd2);
        send_byte(8'h93);
        send_byte(8'h3C);
        send_byte(8'h64);
        expect_empty("filt_drop");
`endif

        // Reset mid-message discards the partial note
        send_byte(8'h90);
        send_byte(8'h3C);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h64);
        expect_empty("rst_mid_msg");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
